nyq_par_loader: RTL and testbench

Write-side master for the NYQ filter's coefficient memory port. Accepts a valid/ready stream of 24-bit configuration words (one header, then N coefficients) and turns it into the `WrEn`/`Addr`/`PAR` write sequence the NYQ block consumes, with auto-incrementing addresses. It sits between the host/config interface and NYQ, and flags completion and range errors.

---
 rtl/nyq_pkg.sv | 29 ++
 rtl/nyq_par_loader_if.sv | 31 +++
 rtl/nyq_par_hdr_chk.sv | 35 +++
 rtl/nyq_par_loader.sv | 154 +++++++++++++++
 tb/tb_nyq_par_loader.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nyq_pkg.sv
// nyq_pkg: shared definitions for the NYQ coefficient loader.
//   - default address / coefficient word widths
//   - header field offsets and the command-bit index (as functions of the
//     widths, so parameterised instances stay consistent)
//   - loader FSM state encoding
package nyq_pkg;

  localparam int unsigned NYQ_ADDR_WIDTH = 11;
  localparam int unsigned NYQ_MEM_WIDTH  = 24;

  // Header layout: [AW-1:0] start address, [2*AW-1:AW] count-1,
  // [MW-1] command bit (must be 1). Remaining bits are don't-care.
  localparam int unsigned HDR_START_LSB = 0;

  function automatic int unsigned hdr_cnt_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned hdr_cmd_bit(input int unsigned mw);
    return mw - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } nyq_state_e;

endpackage

// File: rtl/nyq_par_loader_if.sv
// nyq_par_loader_if: configuration word stream feeding the loader.
//   Cfg_Valid_SI : producer has a word on Cfg_Data_DI
//   Cfg_Data_DI  : header or coefficient word
//   Cfg_Ready_SO : loader accepts the word this cycle
// Handshake: a word moves on a rising edge where valid and ready are both
// high. The producer keeps valid and data stable until that edge; ready may
// depend combinationally on loader state, abort and reset but never on valid.
// Modports: master = producer (host/config side), slave = loader.
interface nyq_par_loader_if
  import nyq_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = NYQ_MEM_WIDTH
) ();

  logic                 Cfg_Valid_SI;
  logic [MEM_WIDTH-1:0] Cfg_Data_DI;
  logic                 Cfg_Ready_SO;

  modport master (
    output Cfg_Valid_SI,
    output Cfg_Data_DI,
    input  Cfg_Ready_SO
  );

  modport slave (
    input  Cfg_Valid_SI,
    input  Cfg_Data_DI,
    output Cfg_Ready_SO
  );

endinterface

// File: rtl/nyq_par_hdr_chk.sv
// nyq_par_hdr_chk: combinational decode of a loader header word.
//   Hdr_DI   : raw header word
//   Start_DO : start address S
//   Last_DO  : C = word count - 1
//   Ok_SO    : command bit set and S+C fits in the address space
module nyq_par_hdr_chk
  import nyq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = NYQ_ADDR_WIDTH,
  parameter int unsigned MEM_WIDTH  = NYQ_MEM_WIDTH
) (
  input  logic [MEM_WIDTH-1:0]  Hdr_DI,
  output logic [ADDR_WIDTH-1:0] Start_DO,
  output logic [ADDR_WIDTH-1:0] Last_DO,
  output logic                  Ok_SO
);

  localparam int unsigned CNT_LSB = hdr_cnt_lsb(ADDR_WIDTH);
  localparam int unsigned CMD_BIT = hdr_cmd_bit(MEM_WIDTH);

  // One extra bit so an end address past the top is seen as a carry
  // instead of wrapping back to a small, legal-looking value.
  logic [ADDR_WIDTH:0] end_addr;

  // Bits between the count field and the command bit carry no meaning.
  logic unused_hdr_bits;

  assign Start_DO = Hdr_DI[HDR_START_LSB +: ADDR_WIDTH];
  assign Last_DO  = Hdr_DI[CNT_LSB +: ADDR_WIDTH];
  assign end_addr = {1'b0, Start_DO} + {1'b0, Last_DO};
  assign Ok_SO    = Hdr_DI[CMD_BIT] & ~end_addr[ADDR_WIDTH];

  assign unused_hdr_bits = ^Hdr_DI[CMD_BIT-1:CNT_LSB+ADDR_WIDTH];

endmodule

// File: rtl/nyq_par_loader.sv
// nyq_par_loader: write-side master for the NYQ coefficient memory port.
// Takes a header word (start address, count-1, command bit) followed by the
// coefficients and emits one registered WrEn/Addr/PAR write per coefficient
// with an auto-incrementing address.
// Ports:
//   Clk_CI, Rst_RI : clock, synchronous active-high reset
//   Abort_SI       : drop the current load, back to IDLE next cycle
//   Cfg_S          : config word stream (slave side)
//   WrEn_SO        : write strobe to NYQ WrEn_SI
//   Addr_DO        : write address to NYQ Addr_DI (holds between writes)
//   PAR_Out_DO     : write data to NYQ PAR_In_DI (holds between writes)
//   Busy_SO        : load in progress (LOAD or DONE)
//   Done_SO        : one-cycle pulse together with the last write
//   Err_SO         : one-cycle pulse after a rejected header
//   Dbg_State_SO   : current FSM state, for observation only
module nyq_par_loader
  import nyq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = NYQ_ADDR_WIDTH,
  parameter int unsigned MEM_WIDTH  = NYQ_MEM_WIDTH
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Abort_SI,
  nyq_par_loader_if.slave       Cfg_S,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic                  Err_SO,
  output nyq_state_e            Dbg_State_SO
);

  nyq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_WIDTH-1:0] remain_q, remain_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  par_q, par_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  ready;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] hdr_start;
  logic [ADDR_WIDTH-1:0] hdr_last;
  logic                  hdr_ok;

  nyq_par_hdr_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH)
  ) u_hdr_chk (
    .Hdr_DI   (Cfg_S.Cfg_Data_DI),
    .Start_DO (hdr_start),
    .Last_DO  (hdr_last),
    .Ok_SO    (hdr_ok)
  );

  // Ready is gated by abort and reset so that a word offered in those
  // cycles is simply not consumed; that alone suppresses any write or
  // header decision for that cycle.
  assign ready = ((state_q == ST_IDLE) | (state_q == ST_LOAD)) & ~Abort_SI & ~Rst_RI;
  assign xfer  = Cfg_S.Cfg_Valid_SI & ready;

  assign Cfg_S.Cfg_Ready_SO = ready;

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    remain_d   = remain_q;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    par_d      = par_q;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (hdr_ok) begin
            addr_cnt_d = hdr_start;
            remain_d   = hdr_last;
            state_d    = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          wren_d     = 1'b1;
          addr_d     = addr_cnt_q;
          par_d      = Cfg_S.Cfg_Data_DI;
          // The counter may step past the top on the final word; that value
          // is never driven out because the FSM leaves LOAD on this transfer.
          addr_cnt_d = addr_cnt_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          if (remain_q == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (Abort_SI) begin
      state_d = ST_IDLE;
    end

    // Busy/Done are registered from the next state so they line up with
    // the state they describe rather than lagging it by a cycle.
    busy_d = (state_d == ST_LOAD) | (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      remain_q   <= '0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      par_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      remain_q   <= remain_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      par_q      <= par_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign WrEn_SO      = wren_q;
  assign Addr_DO      = addr_q;
  assign PAR_Out_DO   = par_q;
  assign Busy_SO      = busy_q;
  assign Done_SO      = done_q;
  assign Err_SO       = err_q;
  assign Dbg_State_SO = state_q;

endmodule

// File: tb/tb_nyq_par_loader.sv
// tb_nyq_par_loader: directed self-checking bench for nyq_par_loader.
module tb_nyq_par_loader;
  import nyq_pkg::*;

  localparam int AW = 11;
  localparam int MW = 24;
  localparam int EW = 1 + AW + MW;   // {done, addr, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  nyq_par_loader_if #(.MEM_WIDTH(MW)) cfg_if ();

  logic          wr_en;
  logic [AW-1:0] addr;
  logic [MW-1:0] par;
  logic          busy;
  logic          done;
  logic          err;
  nyq_state_e    dbg_state;

  nyq_par_loader #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .Abort_SI     (abort),
    .Cfg_S        (cfg_if),
    .WrEn_SO      (wr_en),
    .Addr_DO      (addr),
    .PAR_Out_DO   (par),
    .Busy_SO      (busy),
    .Done_SO      (done),
    .Err_SO       (err),
    .Dbg_State_SO (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int            got_c[$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back({done, addr, par});
      got_c.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  function automatic logic [EW-1:0] mk(input logic d, input int a, input logic [MW-1:0] w);
    logic [AW-1:0] a_b;
    a_b = a[AW-1:0];
    return {d, a_b, w};
  endfunction

  function automatic logic [MW-1:0] hdr(input logic cmd, input logic junk, input int s, input int c);
    logic [MW-1:0] h;
    h = '0;
    h[MW-1] = cmd;
    h[MW-2] = junk;
    h[2*AW-1:AW] = c[AW-1:0];
    h[AW-1:0] = s[AW-1:0];
    return h;
  endfunction

  function automatic void clear_sb();
    exp_q.delete();
    got_q.delete();
    got_c.delete();
    done_cnt = 0;
    err_cnt = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word and returns one tick after the edge that consumed it.
  // waits = cycles spent with ready low.
  task automatic send_word(input logic [MW-1:0] w, output int waits);
    cfg_if.Cfg_Valid_SI = 1'b1;
    cfg_if.Cfg_Data_DI  = w;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (cfg_if.Cfg_Ready_SO === 1'b1) begin
        @(posedge clk);
        #1;
        cfg_if.Cfg_Valid_SI = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      waits++;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: word %h not accepted within 20 cycles, required acceptance", w);
    cfg_if.Cfg_Valid_SI = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cfg_if.Cfg_Valid_SI = 1'b1;
    cfg_if.Cfg_Data_DI  = hdr(1'b1, 1'b0, 0, 0);
    repeat (3) step();
    checks++;
    if ({wr_en, addr, par, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h/%h/%b/%b/%b, required all zero", wr_en, addr, par, busy, done, err);
    end
    checks++;
    if (cfg_if.Cfg_Ready_SO !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 0", cfg_if.Cfg_Ready_SO);
    end
    cfg_if.Cfg_Valid_SI = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_if.Cfg_Ready_SO !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release: ready=%b state=%0d, required ready=1 state=IDLE", cfg_if.Cfg_Ready_SO, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [MW-1:0] d [4];
    d[0] = 24'd10; d[1] = 24'd20; d[2] = 24'd30; d[3] = 24'd40;
    clear_sb();
    send_word(hdr(1'b1, 1'b0, 0, 3), w);
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_LOAD || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hdr: busy=%b state=%0d wren=%b, required 1/LOAD/0", busy, dbg_state, wr_en);
    end
    for (int i = 0; i < 4; i++) begin
      send_word(d[i], w);
      exp_q.push_back(mk(i == 3, i, d[i]));
      if (i == 0) begin
        checks++;
        if (wr_en !== 1'b1 || addr !== 11'd0 || par !== 24'd10) begin
          errors++;
          $display("FAIL b2b_latency: wren=%b addr=%0d par=%0d, required 1/0/10", wr_en, addr, par);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || wr_en !== 1'b1 || addr !== 11'd3) begin
      errors++;
      $display("FAIL b2b_done: done=%b wren=%b addr=%0d, required 1/1/3", done, wr_en, addr);
    end
    step();
    checks++;
    if (done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL b2b_after: done=%b wren=%b busy=%b state=%0d, required 0/0/0/IDLE", done, wr_en, busy, dbg_state);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (got_c[3] - got_c[0] != 3) begin
        errors++;
        $display("FAIL b2b_consecutive: write span %0d cycles, required 3", got_c[3] - got_c[0]);
      end
    end
  endtask

  task automatic test_gaps_top();
    int w;
    logic [MW-1:0] v;
    clear_sb();
    send_word(hdr(1'b1, 1'b1, 2040, 7), w);
    for (int i = 0; i < 8; i++) begin
      v = 24'h5A0000 + 24'(i);
      send_word(v, w);
      exp_q.push_back(mk(i == 7, 2040 + i, v));
      step();
      checks++;
      if (wr_en !== 1'b0 || addr !== 11'(2040 + i) || par !== v) begin
        errors++;
        $display("FAIL gap_hold%0d: wren=%b addr=%0d par=%h, required 0/%0d/%h", i, wr_en, addr, par, 2040 + i, v);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gap_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL gap_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL gap_done_count: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_header_err();
    int w;
    logic [MW-1:0] h [2];
    h[0] = hdr(1'b1, 1'b0, 2045, 3);
    h[1] = hdr(1'b0, 1'b0, 0, 0);
    clear_sb();
    for (int i = 0; i < 2; i++) begin
      send_word(h[i], w);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL err_pulse%0d: err=%b busy=%b state=%0d, required 1/0/IDLE", i, err, busy, dbg_state);
      end
      step();
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_single%0d: err=%b, required 0", i, err);
      end
    end
    // Largest legal end address is accepted; abort to leave it.
    send_word(hdr(1'b1, 1'b0, 2044, 3), w);
    checks++;
    if (err !== 1'b0 || dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL err_edge_ok: err=%b state=%0d, required 0/LOAD", err, dbg_state);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (got_q.size() != 0 || err_cnt != 2 || done_cnt != 0) begin
      errors++;
      $display("FAIL err_totals: writes=%0d errs=%0d dones=%0d, required 0/2/0", got_q.size(), err_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    int w;
    clear_sb();
    send_word(hdr(1'b1, 1'b0, 100, 4), w);
    send_word(24'h111111, w);
    send_word(24'h222222, w);
    exp_q.push_back(mk(1'b0, 100, 24'h111111));
    exp_q.push_back(mk(1'b0, 101, 24'h222222));
    cfg_if.Cfg_Valid_SI = 1'b1;
    cfg_if.Cfg_Data_DI  = 24'h333333;
    abort = 1'b1;
    #3;
    checks++;
    if (cfg_if.Cfg_Ready_SO !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got %b, required 0", cfg_if.Cfg_Ready_SO);
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    cfg_if.Cfg_Valid_SI = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: state=%0d wren=%b busy=%b done=%b, required IDLE/0/0/0", dbg_state, wr_en, busy, done);
    end
    step();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL abort_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL abort_flags: dones=%0d errs=%0d, required 0/0", done_cnt, err_cnt);
    end
    send_word(hdr(1'b1, 1'b0, 10, 0), w);
    checks++;
    if (w != 0 || dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL abort_next_hdr: waits=%0d state=%0d, required 0/LOAD", w, dbg_state);
    end
    send_word(24'h0000AA, w);
    checks++;
    if (wr_en !== 1'b1 || addr !== 11'd10 || par !== 24'h0000AA || done !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_write: wren=%b addr=%0d par=%h done=%b, required 1/10/0000aa/1", wr_en, addr, par, done);
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    int w;
    send_word(hdr(1'b1, 1'b0, 0, 5), w);
    send_word(24'h000001, w);
    send_word(24'h000002, w);
    rst = 1'b1;
    cfg_if.Cfg_Valid_SI = 1'b1;
    cfg_if.Cfg_Data_DI  = 24'h000003;
    #3;
    checks++;
    if (cfg_if.Cfg_Ready_SO !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b, required 0", cfg_if.Cfg_Ready_SO);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({wr_en, addr, par, busy, done, err} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_outputs: %b/%h/%h/%b/%b/%b state=%0d, required zeros/IDLE", wr_en, addr, par, busy, done, err, dbg_state);
    end
    step();
    rst = 1'b0;
    cfg_if.Cfg_Valid_SI = 1'b0;
    clear_sb();
    send_word(hdr(1'b1, 1'b0, 5, 0), w);
    send_word(24'hABCDEF, w);
    checks++;
    if (wr_en !== 1'b1 || addr !== 11'd5 || par !== 24'hABCDEF || done !== 1'b1) begin
      errors++;
      $display("FAIL rst_reload: wren=%b addr=%0d par=%h done=%b, required 1/5/abcdef/1", wr_en, addr, par, done);
    end
    step();
    checks++;
    if (got_q.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL rst_reload_count: writes=%0d dones=%0d, required 1/1", got_q.size(), done_cnt);
    end
  endtask

  task automatic test_hdr_after_done();
    int w;
    send_word(hdr(1'b1, 1'b0, 20, 1), w);
    send_word(24'h0000C1, w);
    send_word(24'h0000C2, w);
    send_word(hdr(1'b1, 1'b0, 30, 0), w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL done_wait: header waited %0d cycles, required 1", w);
    end
    checks++;
    if (dbg_state !== ST_LOAD || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_hdr_accept: state=%0d busy=%b done=%b, required LOAD/1/0", dbg_state, busy, done);
    end
    send_word(24'h0000D0, w);
    checks++;
    if (wr_en !== 1'b1 || addr !== 11'd30 || par !== 24'h0000D0) begin
      errors++;
      $display("FAIL done_next_write: wren=%b addr=%0d par=%h, required 1/30/0000d0", wr_en, addr, par);
    end
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    cfg_if.Cfg_Valid_SI = 1'b0;
    cfg_if.Cfg_Data_DI  = '0;
    test_reset();
    test_back_to_back();
    test_gaps_top();
    test_header_err();
    test_abort();
    test_reset_mid_load();
    test_hdr_after_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
